perf_event_collector: RTL and testbench
=======================================

# perf_event_collector

Performance-event collection stage that consumes per-cycle event pulses from core pipeline stages and accumulates them into per-event counters. It sits directly downstream of the per-module event sources and free-running cycle count. On request it takes an atomic snapshot of all counters and streams it out over a valid/ready port for the difftest/log sink.

## Interface
- NUM_EVENTS, 16, number of event channels (≥2).
- CNT_W, 32, width of each event counter.
- INC_W, 2, width of per-channel increment per cycle (a stage may report up to 2^INC_W−1 events/cycle).
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  counting enable; when 0, event counters hold (cycle counter still runs).
- event_inc  in  NUM_EVENTS*INC_W  packed increments; channel i at bits [i*INC_W +: INC_W].
- clear  in  1  zero all live counters and overflow flags.
- dump_start  in  1  request snapshot + stream-out.
- dump_busy  out  1  dump in progress (snapshot held, stream active).
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  sink accepts beat.
- dump_idx  out  $clog2(NUM_EVENTS)  event index of current beat.
- dump_data  out  CNT_W  snapshotted counter value.
- dump_ovf  out  1  snapshotted sticky overflow flag for this index.
- dump_last  out  1  current beat is index NUM_EVENTS−1.
- cycle_cnt  out  64  free-running cycle counter.

## Operation
- Live counter i: each cycle with en=1, cnt[i] <= cnt[i] + event_inc[i], modulo 2^CNT_W.
- Overflow: if the addition carries out of CNT_W, ovf[i] set; sticky until clear or rst.
- clear: all cnt[i] and ovf[i] become 0 on next edge; the same cycle's increments are dropped (clear wins over increment and en).
- cycle_cnt: +1 every cycle, wraps at 2^64, unaffected by en and clear; reset only by rst.
- FSM states: IDLE, STREAM.
- IDLE: dump_busy=0, dump_valid=0. dump_start=1 -> copy the pre-edge values of all cnt[i] and ovf[i] into shadow registers (the increment of that cycle is not included; it lands in the live counters), set idx=0, go STREAM.
- STREAM: dump_busy=1, dump_valid=1, dump_data/dump_ovf = shadow[idx]. On dump_valid && dump_ready: if idx==NUM_EVENTS−1 go IDLE, else idx+1.
- dump_start in STREAM: ignored (no restart, no re-snapshot).
- clear in STREAM: live counters cleared; shadow and stream unaffected.
- Outputs stable while dump_valid && !dump_ready (standard valid/ready; valid never drops without a handshake).
- Live counting continues uninterrupted during STREAM.

## Timing
- Reset values: all counters, ovf, shadow, cycle_cnt = 0; state IDLE; dump_busy=0, dump_valid=0, dump_idx=0, dump_data=0, dump_ovf=0, dump_last=0.
- Counter update latency: event at cycle t is visible in cnt at t+1 (and in a snapshot taken at t+1 or later).
- dump_start sampled at t -> dump_valid=1 with idx 0 at t+1.
- Full stream with dump_ready held 1: NUM_EVENTS beats on consecutive cycles; dump_busy falls the cycle after the last handshake; a new dump_start is accepted in that cycle (IDLE), so back-to-back dumps have ≥1 idle cycle between streams.
- dump_idx, dump_data, dump_ovf, dump_last are registered or derived only from registered state (no combinational path from inputs).
- dump_last = dump_valid && idx==NUM_EVENTS−1.
- rst mid-stream: next cycle IDLE, all outputs at reset values; the partial dump is abandoned.

## Test plan
- Reset/basic count: drive event_inc[3]=2 for 10 cycles with en=1, then dump with dump_ready=1 -> beat idx 3 data=20, all other beats 0, dump_last only on idx 15, dump_busy low 1 cycle after beat 15.
- Overflow wrap: CNT_W=32, preload cnt[0] to 0xFFFFFFFE via increments, then inc=3 -> cnt[0]=0x00000001, ovf[0]=1; clear -> both 0.
- Clear vs event and en: clear and event_inc[1]=3 in same cycle -> cnt[1]=0; en=0 with event_inc[1]=3 for 5 cycles -> cnt[1] unchanged; cycle_cnt keeps incrementing.
- Snapshot atomicity: dump_start in the cycle with event_inc[2]=1 and cnt[2]=7 -> beat 2 shows 7, live cnt[2]=8; further events and clear during stream do not change beats.
- Backpressure: random dump_ready toggling -> every idx 0..15 delivered exactly once in order, data stable while stalled; dump_start during stream ignored.
- Reset mid-stream: assert rst at beat 5 -> next cycle dump_valid=0, dump_busy=0, cycle_cnt=0; new dump afterwards returns all zeros.

Source files
------------

// File: rtl/perf_event_collector.sv
// Per-channel performance event counters with sticky overflow flags,
// atomic snapshot and valid/ready stream-out of the snapshot.
module perf_event_collector #(
    parameter  int NUM_EVENTS = 16,
    parameter  int CNT_W      = 32,
    parameter  int INC_W      = 2,
    localparam int IDX_W      = $clog2(NUM_EVENTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_EVENTS*INC_W-1:0] event_inc,
    input  logic                        clear,
    input  logic                        dump_start,
    output logic                        dump_busy,
    output logic                        dump_valid,
    input  logic                        dump_ready,
    output logic [IDX_W-1:0]            dump_idx,
    output logic [CNT_W-1:0]            dump_data,
    output logic                        dump_ovf,
    output logic                        dump_last,
    output logic [63:0]                 cycle_cnt
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVENTS - 1);

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [CNT_W-1:0]        cnt_q     [NUM_EVENTS];
    logic [CNT_W-1:0]        cnt_d     [NUM_EVENTS];
    logic [CNT_W:0]          sum       [NUM_EVENTS];
    logic [NUM_EVENTS-1:0]   ovf_q;
    logic [NUM_EVENTS-1:0]   ovf_d;
    logic [CNT_W-1:0]        shd_cnt_q [NUM_EVENTS];
    logic [NUM_EVENTS-1:0]   shd_ovf_q;
    logic [63:0]             cycle_q;

    // Extra top bit of each sum is the carry-out that sets the sticky flag.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            sum[i]   = {1'b0, cnt_q[i]}
                     + (CNT_W+1)'(event_inc[i*INC_W +: INC_W]);
            cnt_d[i] = cnt_q[i];
            if (clear) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (en) begin
                cnt_d[i] = sum[i][CNT_W-1:0];
                ovf_d[i] = ovf_q[i] | sum[i][CNT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= '0;
            ovf_q   <= '0;
            cycle_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            cycle_q <= cycle_q + 64'd1;
        end
    end

    // Snapshot takes pre-edge live values; dump_start is ignored mid-stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int i = 0; i < NUM_EVENTS; i++) shd_cnt_q[i] <= '0;
            shd_ovf_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dump_start) begin
                        shd_cnt_q <= cnt_q;
                        shd_ovf_q <= ovf_q;
                        idx_q     <= '0;
                        state_q   <= STREAM;
                    end
                end
                STREAM: begin
                    if (dump_ready) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dump_busy  = (state_q == STREAM);
    assign dump_valid = (state_q == STREAM);
    assign dump_idx   = idx_q;
    assign dump_data  = shd_cnt_q[idx_q];
    assign dump_ovf   = shd_ovf_q[idx_q];
    assign dump_last  = dump_valid && (idx_q == LAST_IDX);
    assign cycle_cnt  = cycle_q;

endmodule

// File: tb/tb_perf_event_collector.sv
// Bench for perf_event_collector: directed scenarios plus random traffic,
// checked every cycle against an arithmetic reference model.
module tb_perf_event_collector;

    localparam int NE = 16;
    localparam int CW = 8;
    localparam int IW = 2;
    localparam int XW = $clog2(NE);
    localparam int MOD = 2 ** CW;

    logic           clk = 1'b0;
    logic           rst, en, clear, dump_start, dump_ready;
    logic [NE*IW-1:0] event_inc;
    logic           dump_busy, dump_valid, dump_ovf, dump_last;
    logic [XW-1:0]  dump_idx;
    logic [CW-1:0]  dump_data;
    logic [63:0]    cycle_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: live counts, sticky flags, snapshot, stream position
    int              m_cnt [NE];
    bit              m_ovf [NE];
    int              s_cnt [NE];
    bit              s_ovf [NE];
    bit              m_str;
    int              m_idx;
    longint unsigned m_cyc;

    perf_event_collector #(
        .NUM_EVENTS(NE),
        .CNT_W     (CW),
        .INC_W     (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .event_inc (event_inc),
        .clear     (clear),
        .dump_start(dump_start),
        .dump_busy (dump_busy),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_idx  (dump_idx),
        .dump_data (dump_data),
        .dump_ovf  (dump_ovf),
        .dump_last (dump_last),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit was_rst;
        was_rst = rst;
        if (rst) begin
            for (int i = 0; i < NE; i++) begin
                m_cnt[i] = 0; m_ovf[i] = 0;
                s_cnt[i] = 0; s_ovf[i] = 0;
            end
            m_str = 0; m_idx = 0; m_cyc = 0;
        end else begin
            if (!m_str && dump_start) begin
                s_cnt = m_cnt; s_ovf = m_ovf;
                m_str = 1; m_idx = 0;
            end else if (m_str && dump_ready) begin
                if (m_idx == NE - 1) m_str = 0;
                else m_idx++;
            end
            for (int i = 0; i < NE; i++) begin
                int v;
                v = m_cnt[i] + int'(event_inc[i*IW +: IW]);
                if (clear) begin
                    m_cnt[i] = 0; m_ovf[i] = 0;
                end else if (en) begin
                    if (v >= MOD) m_ovf[i] = 1;
                    m_cnt[i] = v % MOD;
                end
            end
            m_cyc++;
        end
        @(posedge clk);
        #1;
        chk("valid", 64'(dump_valid), 64'(m_str));
        chk("busy", 64'(dump_busy), 64'(m_str));
        chk("last", 64'(dump_last), 64'(m_str && m_idx == NE - 1));
        chk("cycle", cycle_cnt, m_cyc);
        if (m_str) begin
            chk("idx", 64'(dump_idx), 64'(m_idx));
            chk("data", 64'(dump_data), 64'(s_cnt[m_idx]));
            chk("ovf", 64'(dump_ovf), 64'(s_ovf[m_idx]));
        end else if (was_rst) begin
            chk("rst_idx", 64'(dump_idx), 64'd0);
            chk("rst_data", 64'(dump_data), 64'd0);
            chk("rst_ovf", 64'(dump_ovf), 64'd0);
        end
    endtask

    task automatic set_inc(int ch, int val);
        event_inc = '0;
        event_inc[ch*IW +: IW] = IW'(val);
    endtask

    task automatic start_dump();
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
    endtask

    task automatic finish_dump();
        dump_ready = 1'b1;
        for (int n = 0; n < 4 * NE && dump_busy; n++) step();
        chk("dump_end", 64'(dump_busy), 64'd0);
    endtask

    task automatic walk_to(int b);
        dump_ready = 1'b1;
        for (int n = 0; n < NE && dump_idx != XW'(b); n++) step();
        chk("walk_idx", 64'(dump_idx), 64'(b));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clear = 1'b0;
        dump_start = 1'b0; dump_ready = 1'b0; event_inc = '0;
        step(); step();
        rst = 1'b0;
        chk("reset_cycle", cycle_cnt, 64'd0);
        chk("reset_busy", 64'(dump_busy), 64'd0);

        // Basic count: channel 3 gets 2 per cycle for 10 cycles
        set_inc(3, 2);
        repeat (10) step();
        event_inc = '0;
        dump_ready = 1'b1;
        start_dump();
        for (int b = 0; b < NE; b++) begin
            chk("basic_idx", 64'(dump_idx), 64'(b));
            chk("basic_data", 64'(dump_data), (b == 3) ? 64'd20 : 64'd0);
            chk("basic_last", 64'(dump_last), 64'(b == NE - 1));
            step();
        end
        chk("basic_busy_low", 64'(dump_busy), 64'd0);

        // Overflow: preload channel 0 to MOD-2, then +3 wraps to 1
        clear = 1'b1; step(); clear = 1'b0;
        set_inc(0, 3);
        repeat ((MOD - 2) / 3) step();
        set_inc(0, (MOD - 2) % 3);
        step();
        set_inc(0, 3);
        step();
        event_inc = '0;
        start_dump();
        chk("ovf_data", 64'(dump_data), 64'd1);
        chk("ovf_flag", 64'(dump_ovf), 64'd1);
        finish_dump();
        clear = 1'b1; step(); clear = 1'b0;
        start_dump();
        chk("clr_data", 64'(dump_data), 64'd0);
        chk("clr_flag", 64'(dump_ovf), 64'd0);
        finish_dump();

        // Clear beats a same-cycle increment; en=0 holds counters
        set_inc(1, 3);
        repeat (3) step();
        clear = 1'b1; step(); clear = 1'b0;
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        event_inc = '0;
        start_dump();
        walk_to(1);
        chk("clr_wins", 64'(dump_data), 64'd0);
        finish_dump();

        // Snapshot atomicity: beat 2 shows 7 though live count moves to 8
        clear = 1'b1; step(); clear = 1'b0;
        set_inc(2, 1);
        repeat (7) step();
        start_dump();
        event_inc = '0;
        walk_to(2);
        chk("snap_pre", 64'(dump_data), 64'd7);
        finish_dump();
        start_dump();
        event_inc = 32'(~0);
        clear = 1'b1; step(); clear = 1'b0;
        walk_to(2);
        chk("snap_live", 64'(dump_data), 64'd8);
        finish_dump();
        event_inc = '0;

        // Random traffic with backpressure and mid-stream dump_start
        for (int n = 0; n < 500; n++) begin
            event_inc  = ($urandom);
            en         = ($urandom_range(0, 3) != 0);
            clear      = ($urandom_range(0, 40) == 0);
            dump_start = ($urandom_range(0, 5) == 0);
            dump_ready = ($urandom_range(0, 1) == 1);
            step();
        end
        clear = 1'b0; dump_start = 1'b0; en = 1'b1;
        finish_dump();

        // Reset mid-stream abandons the dump
        start_dump();
        walk_to(5);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mrst_valid", 64'(dump_valid), 64'd0);
        chk("mrst_busy", 64'(dump_busy), 64'd0);
        chk("mrst_cycle", cycle_cnt, 64'd0);
        event_inc = '0;
        start_dump();
        for (int b = 0; b < NE; b++) begin
            chk("mrst_zero", 64'(dump_data), 64'd0);
            step();
        end
        chk("mrst_done", 64'(dump_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
